// File: rtl/dp_ram_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dp_ram_sweep
// Description : Simple dual-port RAM. Port A writes and port B reads. Read
//               mode (registered or combinational) and the collision policy
//               for registered reads are set by parameters. A clear sequencer
//               zeroes one word per clock after reset, or after a clr request.
//               Writes that arrive during a sweep are dropped and flagged.
// Ports       : clk, rst     - clock and asynchronous active-high reset
//               clr, busy    - start a clear sweep / a sweep is in progress
//               a_we, a_addr, a_din, a_drop
//                            - write port; a_drop pulses when a write is lost
//               b_re, b_addr, b_dout, b_valid
//                            - read port; b_valid marks an accepted read
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_sweep #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int RD_SYNC  = 1,
  parameter int WR_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_drop,
  input  logic          b_re,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout,
  output logic          b_valid
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_CLEAR  = 1'b1;
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          a_drop_q;
  logic [DW-1:0] ram_q [DEPTH];

  // Sequencer next state. clr during a sweep is deliberately not looked at,
  // so a running sweep can never be restarted by a request.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == PTR_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      a_drop_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      a_drop_q  <= busy & a_we;
    end
  end

  assign busy   = (state_q == S_CLEAR);
  assign a_drop = a_drop_q;

  // The array has no reset; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      ram_q[clr_ptr_q] <= '0;
    end else if (a_we) begin
      ram_q[a_addr] <= a_din;
    end
  end

  generate
    if (RD_SYNC != 0) begin : g_rd_sync
      logic [DW-1:0] b_dout_q;
      logic          b_valid_q;
      logic          collide;
      logic [DW-1:0] rd_word;

      // Write-first forwards the incoming data; read-first returns the word
      // the array holds before this edge's write lands.
      assign collide = a_we & (a_addr == b_addr);
      assign rd_word = ((WR_FIRST != 0) && collide) ? a_din : ram_q[b_addr];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b_dout_q  <= '0;
          b_valid_q <= 1'b0;
        end else if (!busy && b_re) begin
          b_dout_q  <= rd_word;
          b_valid_q <= 1'b1;
        end else begin
          b_valid_q <= 1'b0;
        end
      end

      assign b_dout  = b_dout_q;
      assign b_valid = b_valid_q;
    end else begin : g_rd_async
      assign b_dout  = busy ? '0 : ram_q[b_addr];
      assign b_valid = b_re & ~busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dp_ram_sweep
// Description : Directed self-checking bench for dp_ram_sweep. Three
//               instances share every input: registered read-first,
//               registered write-first and combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_ram_sweep;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       a_we = 1'b0;
  logic [3:0] a_addr = '0;
  logic [7:0] a_din = '0;
  logic       b_re = 1'b0;
  logic [3:0] b_addr = '0;

  logic       busy_s, drop_s, valid_s;
  logic [7:0] dout_s;
  logic       busy_w, drop_w, valid_w;
  logic [7:0] dout_w;
  logic       busy_a, drop_a, valid_a;
  logic [7:0] dout_a;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;
  int bad;
  int drops;

  always #5 clk = ~clk;

  dp_ram_sweep #(.AW(4), .DW(8), .RD_SYNC(1), .WR_FIRST(0)) u_sync (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_s),
    .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_drop(drop_s),
    .b_re(b_re), .b_addr(b_addr), .b_dout(dout_s), .b_valid(valid_s)
  );

  dp_ram_sweep #(.AW(4), .DW(8), .RD_SYNC(1), .WR_FIRST(1)) u_wf (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_w),
    .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_drop(drop_w),
    .b_re(b_re), .b_addr(b_addr), .b_dout(dout_w), .b_valid(valid_w)
  );

  dp_ram_sweep #(.AW(4), .DW(8), .RD_SYNC(0), .WR_FIRST(0)) u_async (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
    .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_drop(drop_a),
    .b_re(b_re), .b_addr(b_addr), .b_dout(dout_a), .b_valid(valid_a)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    a_we   = 1'b1;
    a_addr = addr;
    a_din  = data;
    step();
    a_we   = 1'b0;
  endtask

  // Counts edges until busy falls; sync read must stay invalid throughout,
  // async output must read as zero/invalid while busy.
  task automatic count_sweep(output int edges, output int errs);
    edges = 0;
    errs  = 0;
    while (busy_s && edges < 40) begin
      if (valid_a !== 1'b0 || dout_a !== 8'h00) errs++;
      step();
      edges++;
      if (valid_s !== 1'b0) errs++;
    end
  endtask

  task automatic read_all_zero(input string tag);
    int errs;
    errs = 0;
    b_re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_addr = 4'(i);
      #1;
      if (valid_a !== 1'b1 || dout_a !== 8'h00) errs++;
      step();
      if (valid_s !== 1'b1 || dout_s !== 8'h00) errs++;
      if (valid_w !== 1'b1 || dout_w !== 8'h00) errs++;
    end
    b_re = 1'b0;
    check(tag, errs, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    step();
    check("rst_busy",   {busy_s, busy_w, busy_a}, 3'b111);
    check("rst_dout",   dout_s, 8'h00);
    check("rst_valid",  {valid_s, valid_w, valid_a}, 3'b000);
    check("rst_drop",   {drop_s, drop_w, drop_a}, 3'b000);
    check("rst_async0", dout_a, 8'h00);

    // Power-up sweep: 16 edges after release, reads blocked meanwhile.
    rst  = 1'b0;
    b_re = 1'b1;
    count_sweep(cnt, bad);
    check("rst_sweep_len", cnt, 16);
    check("rst_sweep_rd_blocked", bad, 0);
    b_re = 1'b0;
    read_all_zero("rd_all_zero_after_rst");

    // Registered read latency and hold.
    wr(4'd3, 8'hA5);
    b_re   = 1'b1;
    b_addr = 4'd3;
    check("rd_pre_edge", {valid_s, dout_s}, {1'b0, 8'h00});
    step();
    check("rd_a5", {valid_s, dout_s}, {1'b1, 8'hA5});
    b_re = 1'b0;
    step();
    check("rd_a5_hold", {valid_s, dout_s}, {1'b0, 8'hA5});

    // Collision at address 7: old 0x11, new 0x22.
    wr(4'd7, 8'h11);
    a_we   = 1'b1;
    a_addr = 4'd7;
    a_din  = 8'h22;
    b_re   = 1'b1;
    b_addr = 4'd7;
    #1;
    check("coll_async_old", dout_a, 8'h11);
    step();
    a_we = 1'b0;
    check("coll_read_first", dout_s, 8'h11);
    check("coll_write_first", dout_w, 8'h22);
    check("coll_async_new", dout_a, 8'h22);
    step();
    check("coll_after_rf", dout_s, 8'h22);
    check("coll_after_wf", dout_w, 8'h22);
    b_re = 1'b0;

    // Combinational read in the same cycle as the address.
    wr(4'd9, 8'h3C);
    b_addr = 4'd9;
    b_re   = 1'b1;
    #1;
    check("async_3c", {valid_a, dout_a}, {1'b1, 8'h3C});
    b_re = 1'b0;

    // Fill, then clear on request with a dropped write and an ignored clr.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF);
    b_re   = 1'b1;
    b_addr = 4'd5;
    step();
    check("fill_ff", dout_s, 8'hFF);
    clr = 1'b1;
    step();
    clr   = 1'b0;
    cnt   = 1;
    drops = 0;
    bad   = 0;
    while (busy_s && cnt < 40) begin
      if (cnt == 3) begin
        a_we   = 1'b1;
        a_addr = 4'd2;
        a_din  = 8'h5A;
        clr    = 1'b1;
      end else begin
        a_we = 1'b0;
        clr  = 1'b0;
      end
      if (valid_a !== 1'b0 || dout_a !== 8'h00) bad++;
      step();
      cnt++;
      if (drop_s) drops++;
      if (valid_s !== 1'b0) bad++;
    end
    a_we = 1'b0;
    clr  = 1'b0;
    b_re = 1'b0;
    check("clr_busy_len", cnt, 17);
    check("clr_drop_pulses", drops, 1);
    check("clr_rd_blocked", bad, 0);
    step();
    check("drop_cleared", drop_s, 1'b0);
    read_all_zero("rd_all_zero_after_clr");

    // Reset in the middle of a sweep.
    wr(4'd4, 8'hC3);
    b_re   = 1'b1;
    b_addr = 4'd4;
    step();
    check("rd_c3", dout_s, 8'hC3);
    b_re = 1'b0;
    clr  = 1'b1;
    step();
    clr = 1'b0;
    repeat (8) step();
    check("mid_sweep_hold", {busy_s, dout_s}, {1'b1, 8'hC3});
    rst = 1'b1;
    #1;
    check("mid_rst_out", {busy_s, valid_s, dout_s}, {1'b1, 1'b0, 8'h00});
    step();
    step();
    rst  = 1'b0;
    b_re = 1'b1;
    count_sweep(cnt, bad);
    check("mid_rst_sweep_len", cnt, 16);
    check("mid_rst_rd_blocked", bad, 0);
    b_re = 1'b0;
    read_all_zero("rd_all_zero_after_mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dp_ram_sweep.md
Name: dp_ram_sweep

Overview:
- Parametrised simple dual-port RAM: one write port (A), one read port (B).
- Compile-time choice of synchronous or asynchronous read.
- Compile-time read/write collision policy.
- Hardware clear sequencer: zeroes the array one word per cycle after reset or on request.
- Sits between board input logic (switches/keys) and the display driver, with the same role as the team's existing single-port RAM experiment block.

Parameters:
- AW, 4, address width; depth = 2^AW words.
- DW, 8, data width in bits.
- RD_SYNC, 1, 1 = registered read (1-cycle latency); 0 = combinational read.
- WR_FIRST, 0, sync-read collision policy: 1 = write-first (new data), 0 = read-first (old data).

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- clr, input, 1, single-cycle request to start a clear sweep.
- busy, output, 1, high while a clear sweep is in progress.
- a_we, input, 1, port A write enable.
- a_addr, input, AW, port A write address.
- a_din, input, DW, port A write data.
- a_drop, output, 1, one-cycle pulse: a write was discarded because busy was high.
- b_re, input, 1, port B read enable.
- b_addr, input, AW, port B read address.
- b_dout, output, DW, port B read data.
- b_valid, output, 1, b_dout holds data for an accepted read.

Behaviour:
- Clock and reset: clock clk; reset rst, asynchronous, active-high.
- FSM states: IDLE, CLEAR. The state register, clr_ptr[AW-1:0], b_dout register, b_valid register and a_drop reset asynchronously. The RAM array does not reset asynchronously.
- On rst high:
  - state = CLEAR, clr_ptr = 0, busy = 1.
  - b_dout = 0, b_valid = 0, a_drop = 0.
- CLEAR state, each rising edge:
  - ram[clr_ptr] <= 0, clr_ptr <= clr_ptr + 1.
  - The edge that writes address 2^AW-1 moves state to IDLE; clr_ptr wraps to 0.
  - busy = (state == CLEAR), so busy is high for exactly 2^AW rising edges after rst falls.
- IDLE state with clr = 1: next state = CLEAR, clr_ptr = 0. The sweep starts on the following edge, so busy lasts 2^AW+1 cycles counting the request edge. clr while in CLEAR is ignored; the sweep does not restart.
- Writes:
  - In IDLE with a_we = 1: ram[a_addr] <= a_din at the edge.
  - In CLEAR with a_we = 1: the write is discarded and a_drop = 1 for the next cycle. Otherwise a_drop = 0.
  - clr and a_we on the same IDLE edge: the write is performed, then the sweep begins (the sweep later erases it).
- Synchronous read (RD_SYNC = 1):
  - IDLE with b_re = 1: b_dout <= ram[b_addr] at the edge, b_valid <= 1. Latency is 1 cycle.
  - b_re = 0 in IDLE: b_valid <= 0, b_dout holds its last value.
  - CLEAR with b_re = 1: read rejected, b_valid <= 0, b_dout holds.
  - Collision (IDLE, a_we & b_re, a_addr == b_addr): WR_FIRST = 1 gives b_dout <= a_din; WR_FIRST = 0 gives b_dout <= old ram word.
- Asynchronous read (RD_SYNC = 0):
  - b_dout = busy ? 0 : ram[b_addr], combinational.
  - b_valid = b_re & ~busy.
  - On collision, b_dout shows the old word until the write edge, then the new word. WR_FIRST has no effect in this mode.
- Address widths are exact; no out-of-range addresses exist. clr_ptr wraps modulo 2^AW.
- rst asserted mid-sweep or mid-write: the sweep restarts at address 0. Words already written keep their value until the sweep reaches them. Pending read output is cleared to 0 and b_valid to 0.

Test Plan:
- Reset release with AW = 4: busy stays high for 16 edges then drops. A read of every address returns 0x00 with b_valid = 1.
- RD_SYNC = 1: write 0xA5 to addr 3, then b_re at addr 3 → b_dout = 0xA5 and b_valid = 1 exactly one edge after the request; with b_re = 0 the next cycle, b_valid = 0 and b_dout stays 0xA5.
- Collision at addr 7 (old value 0x11, write 0x22): WR_FIRST = 0 → b_dout = 0x11; WR_FIRST = 1 → b_dout = 0x22; in both cases a following read gives 0x22.
- Pulse clr after filling addresses 0–15 with 0xFF; issue a_we of 0x5A to addr 2 during the sweep → a_drop pulses once, busy is high for 17 cycles, and all addresses read back 0x00 afterwards.
- RD_SYNC = 0: write 0x3C to addr 9, set b_addr = 9 → b_dout = 0x3C combinationally in the same cycle. During busy → b_dout = 0x00 and b_valid = 0.
- Assert rst when clr_ptr = 8 → busy stays high and clr_ptr = 0. After release the sweep takes 16 full edges and b_valid = 0 throughout.
